// File: rtl/siso_deser_pkg.sv
// Shared types and helpers for the SISO word deserializer.
// The optional parity feature is enabled by defining SISO_DESER_PARITY_EN.
package siso_deser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        PARITY  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 16;

    // Width needed to count 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/siso_deser_out_buf.sv
// One-entry valid/ready output buffer: loads when empty or draining in the same cycle,
// otherwise reports the incoming word as dropped and keeps its contents.
module siso_deser_out_buf
    import siso_deser_pkg::*;
#(
    parameter int DW = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [DW-1:0] data_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic          accepted_o,
    output logic          dropped_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q, data_d;
    logic          can_load;

    assign accepted_o = valid_q & ready_i;
    assign can_load   = ~valid_q | ready_i;
    assign dropped_o  = load_i & ~can_load;

    // Data is only rewritten on a load, so it holds after the consumer drains it.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i && can_load) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (accepted_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/siso_word_deserializer.sv
// Serial-to-parallel word receiver: MSB-first strobed capture into a one-entry output buffer.
// Define SISO_DESER_PARITY_EN to add a trailing even-parity bit per word and Parity_Error_Out.
module siso_word_deserializer
    import siso_deser_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                          Clk_In,
    input  logic                          Reset_N_In,
    input  logic                          Enable_In,
    input  logic                          Frame_Start_In,
    input  logic                          Shift_Data_Signal_In,
    input  logic                          Serial_Data_In,
    output logic [WIDTH-1:0]              Parallel_Data_Out,
    output logic                          Data_Valid_Out,
    input  logic                          Data_Ready_In,
    output logic [cnt_width(WIDTH)-1:0]   Bit_Count_Out,
`ifdef SISO_DESER_PARITY_EN
    output logic                          Parity_Error_Out,
`endif
    output logic [1:0]                    Fsm_State_Out,
    output logic                          Overflow_Out,
    input  logic                          Overflow_Clear_In
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);
`ifdef SISO_DESER_PARITY_EN
    localparam int BW = WIDTH + 1;
`else
    localparam int BW = WIDTH;
`endif

    state_t            state_q, state_d, after_word;
    logic [WIDTH-1:0]  sreg_q, sreg_d, shifted;
    logic [CW-1:0]     count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              fs, sh, word_done;
    logic [BW-1:0]     buf_in, buf_out;
    logic              buf_dropped, unused_accepted;

    assign fs         = Enable_In & Frame_Start_In;
    assign sh         = Enable_In & Shift_Data_Signal_In;
    assign shifted    = {sreg_q[WIDTH-2:0], Serial_Data_In};
    assign after_word = CONTINUOUS ? RECEIVE : IDLE;

    // A frame start always wins and restarts the word, capturing a coincident bit.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        count_d   = count_q;
        word_done = 1'b0;
        if (fs) begin
            state_d = RECEIVE;
            count_d = '0;
            if (sh) begin
                sreg_d  = shifted;
                count_d = ONE;
            end
        end else if (sh) begin
            case (state_q)
                RECEIVE: begin
                    sreg_d = shifted;
                    if (count_q == LAST_IDX) begin
`ifdef SISO_DESER_PARITY_EN
                        state_d = PARITY;
                        count_d = CW'(WIDTH);
`else
                        state_d   = after_word;
                        count_d   = '0;
                        word_done = 1'b1;
`endif
                    end else begin
                        count_d = count_q + ONE;
                    end
                end
                PARITY: begin
                    state_d   = after_word;
                    count_d   = '0;
                    word_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SISO_DESER_PARITY_EN
    // Error flag is set when data plus parity bit carry an odd number of ones.
    assign buf_in = {^{sreg_q, Serial_Data_In}, sreg_q};
`else
    assign buf_in = shifted;
`endif

    always_comb begin
        ovf_d = ovf_q;
        if (Overflow_Clear_In) ovf_d = 1'b0;
        if (buf_dropped)       ovf_d = 1'b1;
    end

    always_ff @(posedge Clk_In or negedge Reset_N_In) begin
        if (!Reset_N_In) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    siso_deser_out_buf #(
        .DW (BW)
    ) u_out_buf (
        .clk        (Clk_In),
        .rst_n      (Reset_N_In),
        .load_i     (word_done),
        .data_i     (buf_in),
        .ready_i    (Data_Ready_In),
        .valid_o    (Data_Valid_Out),
        .data_o     (buf_out),
        .accepted_o (unused_accepted),
        .dropped_o  (buf_dropped)
    );

    assign Parallel_Data_Out = buf_out[WIDTH-1:0];
`ifdef SISO_DESER_PARITY_EN
    assign Parity_Error_Out  = buf_out[WIDTH];
`endif
    assign Bit_Count_Out     = count_q;
    assign Overflow_Out      = ovf_q;
    assign Fsm_State_Out     = state_q;

endmodule
